// File: rtl/timer_seq_pkg.sv
// Shared types and constants for the CoreTimer APB sequencer.
// The RD_LOAD state exists only when TIMER_SEQ_READBACK_EN is defined.
package timer_seq_pkg;

  typedef enum logic [3:0] {
    IDLE,
    WR_LOAD,
    WR_PRESC,
    WR_CTRL,
`ifdef TIMER_SEQ_READBACK_EN
    RD_LOAD,
`endif
    RUN,
    CLR_INT,
    CLR_WAIT,
    WR_STOP
  } seq_state_t;

  // Timer register word addresses (byte address [4:2]).
  localparam logic [2:0] ADDR_LOAD   = 3'd0;
  localparam logic [2:0] ADDR_VALUE  = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_PRESC  = 3'd3;
  localparam logic [2:0] ADDR_INTCLR = 3'd4;
  localparam logic [2:0] ADDR_RIS    = 3'd5;
  localparam logic [2:0] ADDR_MIS    = 3'd6;

  localparam int CTRL_EN_BIT = 0;
  localparam int CTRL_IE_BIT = 1;
  localparam int CTRL_OS_BIT = 2;

  function automatic logic [31:0] ctrl_word(input logic en, input logic ie, input logic os);
    logic [31:0] w;
    w              = '0;
    w[CTRL_EN_BIT] = en;
    w[CTRL_IE_BIT] = ie;
    w[CTRL_OS_BIT] = os;
    return w;
  endfunction

endpackage

// File: rtl/apb_wr_engine.sv
// Two-cycle APB3 master transfer unit: setup while req is first seen, access on the next cycle.
// The requester holds req, addr, write and wdata steady for the whole transfer.
module apb_wr_engine (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        write,
  input  logic [2:0]  addr,
  input  logic [31:0] wdata,
  output logic        done,
  output logic [31:0] rdata,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [2:0]  paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata
);

  logic access_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      access_q <= 1'b0;
    end else begin
      access_q <= req && !access_q;
    end
  end

  // Bus signals are gated by req so an idle bus reads all-zero, and reset drops PSEL at once.
  assign psel    = req;
  assign penable = req && access_q;
  assign pwrite  = req && write;
  assign paddr   = req ? addr  : 3'd0;
  assign pwdata  = req ? wdata : 32'd0;
  assign done    = req && access_q;
  assign rdata   = prdata;

endmodule

// File: rtl/timer_apb_sequencer.sv
// APB3 master that programs a CoreTimer-class slave, then clears and counts its interrupts.
// Define TIMER_SEQ_READBACK_EN to add a LOAD read-back check reported on cfg_err.
module timer_apb_sequencer
  import timer_seq_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter bit          CTRL_IE = 1'b1
) (
  input  logic             PCLK,
  input  logic             PRESETn,
  input  logic             cfg_start,
  input  logic [31:0]      cfg_load,
  input  logic [3:0]       cfg_prescale,
  input  logic             cfg_oneshot,
  input  logic             stop,
  output logic             PSEL,
  output logic             PENABLE,
  output logic             PWRITE,
  output logic [2:0]       PADDR,
  output logic [31:0]      PWDATA,
  input  logic [31:0]      PRDATA,
  input  logic             TIMINT,
  output logic             busy,
  output logic             running,
  output logic             tick_pulse,
`ifdef TIMER_SEQ_READBACK_EN
  output logic             cfg_err,
`endif
  output logic [CNT_W-1:0] tick_count
);

  seq_state_t state_q, state_d;

  logic [31:0]      load_q;
  logic [3:0]       presc_q;
  logic             oneshot_q;
  logic             stop_pend_q;
  logic             stop_path_q;
  logic [CNT_W-1:0] tick_count_q;

  logic        req;
  logic        wr;
  logic [2:0]  addr;
  logic [31:0] wdata;
  logic        done;
  logic [31:0] rdata;
  logic        start_ok;
  logic        count_en;

  assign start_ok = (state_q == IDLE) && cfg_start;

  apb_wr_engine u_apb (
    .clk     (PCLK),
    .rst_n   (PRESETn),
    .req     (req),
    .write   (wr),
    .addr    (addr),
    .wdata   (wdata),
    .done    (done),
    .rdata   (rdata),
    .psel    (PSEL),
    .penable (PENABLE),
    .pwrite  (PWRITE),
    .paddr   (PADDR),
    .pwdata  (PWDATA),
    .prdata  (PRDATA)
  );

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    req     = 1'b0;
    wr      = 1'b0;
    addr    = ADDR_LOAD;
    wdata   = '0;
    unique case (state_q)
      IDLE: begin
        if (cfg_start) state_d = WR_LOAD;
      end
      WR_LOAD: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_LOAD;
        wdata = load_q;
        if (done) state_d = WR_PRESC;
      end
      WR_PRESC: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_PRESC;
        wdata = {28'd0, presc_q};
        if (done) state_d = WR_CTRL;
      end
      WR_CTRL: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_CTRL;
        wdata = ctrl_word(1'b1, CTRL_IE, oneshot_q);
`ifdef TIMER_SEQ_READBACK_EN
        if (done) state_d = RD_LOAD;
`else
        if (done) state_d = RUN;
`endif
      end
`ifdef TIMER_SEQ_READBACK_EN
      RD_LOAD: begin
        req  = 1'b1;
        addr = ADDR_LOAD;
        if (done) state_d = RUN;
      end
`endif
      RUN: begin
        // Stop outranks a simultaneous interrupt; the stop path still clears it.
        if (stop || stop_pend_q) state_d = WR_STOP;
        else if (TIMINT)         state_d = CLR_INT;
      end
      WR_STOP: begin
        req  = 1'b1;
        wr   = 1'b1;
        addr = ADDR_CTRL;
        if (done) state_d = CLR_INT;
      end
      CLR_INT: begin
        req   = 1'b1;
        wr    = 1'b1;
        addr  = ADDR_INTCLR;
        wdata = 32'd1;
        if (done) begin
          if (stop_path_q || oneshot_q) state_d = IDLE;
          else                          state_d = CLR_WAIT;
        end
      end
      CLR_WAIT: begin
        // TIMINT is still high for a cycle after the clear lands in the slave.
        state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: configuration registers are reset as well, so nothing reads X before the first start.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      load_q    <= '0;
      presc_q   <= '0;
      oneshot_q <= 1'b0;
    end else if (start_ok) begin
      load_q    <= cfg_load;
      presc_q   <= cfg_prescale;
      oneshot_q <= cfg_oneshot;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      stop_pend_q <= 1'b0;
      stop_path_q <= 1'b0;
    end else begin
      if (state_d == IDLE)
        stop_pend_q <= 1'b0;
      else if (stop && state_q != IDLE && state_q != RUN)
        stop_pend_q <= 1'b1;

      if (state_d == IDLE)
        stop_path_q <= 1'b0;
      else if (state_q == RUN && state_d == WR_STOP)
        stop_path_q <= 1'b1;
    end
  end

  assign count_en = (state_q == CLR_INT) && done && !stop_path_q;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      tick_count_q <= '0;
    end else if (start_ok) begin
      tick_count_q <= '0;
    end else if (count_en) begin
      tick_count_q <= tick_count_q + CNT_W'(1);
    end
  end

`ifdef TIMER_SEQ_READBACK_EN
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cfg_err <= 1'b0;
    end else if (start_ok) begin
      cfg_err <= 1'b0;
    end else if (state_q == RD_LOAD && done && rdata != load_q) begin
      cfg_err <= 1'b1;
    end
  end
`else
  logic unused_rdata;
  assign unused_rdata = ^rdata;
`endif

  assign busy       = (state_q != IDLE);
  assign running    = (state_q == RUN) || (state_q == CLR_WAIT);
  assign tick_pulse = count_en;
  assign tick_count = tick_count_q;

endmodule
